// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: req/ack memory fetch, valid/ready handoff to decode, PC redirect,
// stop and halt-word detection. Define FETCH_STEP_EN to add a single-fetch step_i input.
module fetch_seq #(
  parameter int unsigned    AW        = 12,
  parameter int unsigned    DW        = 16,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [DW-1:0]  HALT_WORD = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_i,
  input  logic          stop_i,
`ifdef FETCH_STEP_EN
  input  logic          step_i,
`endif
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_addr_i,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          ir_valid_o,
  input  logic          ir_ready_i,
  output logic [DW-1:0] ir_o,
  output logic [AW-1:0] ir_pc_o,
  output logic [AW-1:0] pc_o,
  output logic [1:0]    state_o,
  output logic          halted_o
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StHold = 2'b10,
    StHalt = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic          redir_pend_q, redir_pend_d;
  logic [AW-1:0] redir_addr_q, redir_addr_d;

  logic          go;
  logic          idle_start;

  always_comb begin
    go = run_i & ~stop_i;
`ifdef FETCH_STEP_EN
    idle_start = go | (step_i & ~stop_i);
`else
    idle_start = go;
`endif
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;

    case (state_q)
      StIdle: begin
        if (redirect_i) pc_d = redirect_addr_i;
        if (idle_start) state_d = StReq;
      end

      StReq: begin
        if (mem_ack_i) begin
          if (redir_pend_q || redirect_i) begin
            // Data belongs to the stale path: drop it and reissue from the target.
            pc_d         = redirect_i ? redirect_addr_i : redir_addr_q;
            redir_pend_d = 1'b0;
          end else if (mem_rdata_i == HALT_WORD) begin
            ir_d    = mem_rdata_i;
            ir_pc_d = pc_q;
            state_d = StHalt;
          end else begin
            ir_d       = mem_rdata_i;
            ir_pc_d    = pc_q;
            pc_d       = pc_q + AW'(1);
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (redirect_i) begin
          // The outstanding request cannot be withdrawn, so remember where to go afterwards.
          redir_pend_d = 1'b1;
          redir_addr_d = redirect_addr_i;
        end
      end

      StHold: begin
        if (redirect_i) begin
          ir_valid_d = 1'b0;
          pc_d       = redirect_addr_i;
          state_d    = go ? StReq : StIdle;
        end else if (ir_ready_i) begin
          ir_valid_d = 1'b0;
          state_d    = go ? StReq : StIdle;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
    end
  end

  always_comb begin
    mem_req_o  = (state_q == StReq);
    mem_addr_o = pc_q;
    ir_valid_o = ir_valid_q;
    ir_o       = ir_q;
    ir_pc_o    = ir_pc_q;
    pc_o       = pc_q;
    state_o    = state_q;
    halted_o   = (state_q == StHalt);
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq with a variable-latency memory model.
module tb_fetch_seq;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        stop;
`ifdef FETCH_STEP_EN
  logic        step;
`endif
  logic        redirect;
  logic [11:0] redirect_addr;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir;
  logic [11:0] ir_pc;
  logic [11:0] pc;
  logic [1:0]  state;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [4096];
  logic [3:0]  ack_delay;
  logic [3:0]  wcnt;

  logic [31:0] xfer_log [$];
  logic [31:0] ack_addrs [$];
  int          vld_cycles;
  int          req_cycles;
  int          stab_err;
  logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redir;
  logic [11:0] prev_addr;
  logic [15:0] prev_ir;

  fetch_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_i          (run),
    .stop_i         (stop),
`ifdef FETCH_STEP_EN
    .step_i         (step),
`endif
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .mem_ack_i      (mem_ack),
    .ir_valid_o     (ir_valid),
    .ir_ready_i     (ir_ready),
    .ir_o           (ir),
    .ir_pc_o        (ir_pc),
    .pc_o           (pc),
    .state_o        (state),
    .halted_o       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory acks after ack_delay wait cycles; delay 0 acks in the first request cycle.
  assign mem_ack   = mem_req && (wcnt == ack_delay);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wcnt <= '0;
    else if (mem_ack) wcnt <= '0;
    else if (mem_req) wcnt <= wcnt + 4'd1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_log.delete();
      ack_addrs.delete();
      vld_cycles <= 0;
      req_cycles <= 0;
      stab_err   <= 0;
      prev_req   <= 1'b0;
      prev_ack   <= 1'b0;
      prev_valid <= 1'b0;
      prev_ready <= 1'b0;
      prev_redir <= 1'b0;
      prev_addr  <= '0;
      prev_ir    <= '0;
    end else begin
      if (prev_req && !prev_ack && mem_req && mem_addr != prev_addr) stab_err <= stab_err + 1;
      if (prev_valid && !prev_ready && !prev_redir && ir_valid && ir != prev_ir)
        stab_err <= stab_err + 1;
      if (ir_valid && ir_ready && !redirect) xfer_log.push_back({4'h0, ir_pc, ir});
      if (mem_req && mem_ack) ack_addrs.push_back({20'h0, mem_addr});
      if (ir_valid) vld_cycles <= vld_cycles + 1;
      if (mem_req)  req_cycles <= req_cycles + 1;
      prev_req   <= mem_req;
      prev_ack   <= mem_ack;
      prev_valid <= ir_valid;
      prev_ready <= ir_ready;
      prev_redir <= redirect;
      prev_addr  <= mem_addr;
      prev_ir    <= ir;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] st, input string tag);
    int n = 0;
    while (state != st && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {30'h0, state}, {30'h0, st});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    run           = 1'b0;
    stop          = 1'b0;
`ifdef FETCH_STEP_EN
    step          = 1'b0;
`endif
    redirect      = 1'b0;
    redirect_addr = '0;
    ir_ready      = 1'b0;
    ack_delay     = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h1234;
    mem[1]     = 16'h5678;
    mem[2]     = 16'h9ABC;
    mem[3]     = 16'h1111;
    mem[4]     = 16'hFFFF;
    mem[12'h100] = 16'h0A0A;
    mem[12'h101] = 16'h0B0B;
    mem[12'hFFF] = 16'h0123;

    // Reset state
    do_reset();
    check_eq("rst state", {30'h0, state}, 32'h0);
    check_eq("rst pc", {20'h0, pc}, 32'h0);
    check_eq("rst ir", {16'h0, ir}, 32'h0);
    check_eq("rst ir_pc", {20'h0, ir_pc}, 32'h0);
    check_eq("rst ir_valid", {31'h0, ir_valid}, 32'h0);
    check_eq("rst mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("rst halted", {31'h0, halted}, 32'h0);

    // Zero-wait streaming of three words
    ir_ready = 1'b1;
    run      = 1'b1;
    begin
      int n = 0;
      while (!(state == 2'b10 && ir_pc == 12'd2) && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    run = 1'b0;
    tick(1);
    check_eq("t1 log size", xfer_log.size(), 3);
    check_eq("t1 word0", xfer_log[0], {4'h0, 12'h000, 16'h1234});
    check_eq("t1 word1", xfer_log[1], {4'h0, 12'h001, 16'h5678});
    check_eq("t1 word2", xfer_log[2], {4'h0, 12'h002, 16'h9ABC});
    check_eq("t1 valid cycles", vld_cycles, 3);
    check_eq("t1 pc", {20'h0, pc}, 32'h3);
    check_eq("t1 state", {30'h0, state}, 32'h0);

    // Slow memory and stalled decode
    do_reset();
    ack_delay = 4'd3;
    run       = 1'b1;
    wait_state(2'b10, "t2 hold0");
    tick(2);
    check_eq("t2 ir stalled0", {16'h0, ir}, 32'h1234);
    check_eq("t2 valid stalled0", {31'h0, ir_valid}, 32'h1);
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    wait_state(2'b10, "t2 hold1");
    tick(2);
    check_eq("t2 ir stalled1", {16'h0, ir}, 32'h5678);
    ir_ready = 1'b1;
    run      = 1'b0;
    tick(1);
    ir_ready = 1'b0;
    check_eq("t2 state", {30'h0, state}, 32'h0);
    check_eq("t2 log size", xfer_log.size(), 2);
    check_eq("t2 word0", xfer_log[0], {4'h0, 12'h000, 16'h1234});
    check_eq("t2 word1", xfer_log[1], {4'h0, 12'h001, 16'h5678});
    check_eq("t2 req cycles", req_cycles, 8);
    check_eq("t2 stability", stab_err, 0);

    // Halt word
    do_reset();
    ir_ready      = 1'b1;
    run           = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 12'h004;
    tick(1);
    redirect = 1'b0;
    tick(3);
    check_eq("t3 state", {30'h0, state}, 32'h3);
    check_eq("t3 halted", {31'h0, halted}, 32'h1);
    check_eq("t3 ir", {16'h0, ir}, 32'hFFFF);
    check_eq("t3 ir_pc", {20'h0, ir_pc}, 32'h4);
    check_eq("t3 pc", {20'h0, pc}, 32'h4);
    check_eq("t3 valid cycles", vld_cycles, 0);
    check_eq("t3 mem_req", {31'h0, mem_req}, 32'h0);
    redirect      = 1'b1;
    redirect_addr = 12'h010;
    tick(1);
    redirect = 1'b0;
    tick(3);
    check_eq("t3 state after redir", {30'h0, state}, 32'h3);
    check_eq("t3 pc after redir", {20'h0, pc}, 32'h4);
    do_reset();
    check_eq("t3 state after reset", {30'h0, state}, 32'h0);
    check_eq("t3 halted after reset", {31'h0, halted}, 32'h0);

    // Redirect two cycles before a delayed ack
    ack_delay = 4'd3;
    ir_ready  = 1'b1;
    run       = 1'b1;
    wait_state(2'b01, "t4a req");
    run = 1'b0;
    tick(1);
    redirect      = 1'b1;
    redirect_addr = 12'h100;
    tick(1);
    redirect = 1'b0;
    wait_state(2'b10, "t4a hold");
    check_eq("t4a ir", {16'h0, ir}, 32'h0A0A);
    check_eq("t4a ir_pc", {20'h0, ir_pc}, 32'h100);
    tick(1);
    check_eq("t4a log size", xfer_log.size(), 1);
    check_eq("t4a ack count", ack_addrs.size(), 2);
    check_eq("t4a ack addr0", ack_addrs[0], 32'h000);
    check_eq("t4a ack addr1", ack_addrs[1], 32'h100);
    check_eq("t4a pc", {20'h0, pc}, 32'h101);
    check_eq("t4a stability", stab_err, 0);

    // Redirect coincident with ack
    do_reset();
    ir_ready = 1'b1;
    run      = 1'b1;
    tick(1);
    check_eq("t4b ack now", {31'h0, mem_ack}, 32'h1);
    redirect      = 1'b1;
    redirect_addr = 12'h100;
    run           = 1'b0;
    tick(1);
    redirect = 1'b0;
    wait_state(2'b10, "t4b hold");
    check_eq("t4b ir", {16'h0, ir}, 32'h0A0A);
    check_eq("t4b ir_pc", {20'h0, ir_pc}, 32'h100);
    tick(1);
    check_eq("t4b log size", xfer_log.size(), 1);
    check_eq("t4b ack addr1", ack_addrs[1], 32'h100);

    // Redirect in HOLD flushes ir_valid
    do_reset();
    run = 1'b1;
    wait_state(2'b10, "t4c hold");
    check_eq("t4c valid before", {31'h0, ir_valid}, 32'h1);
    redirect      = 1'b1;
    redirect_addr = 12'h100;
    ir_ready      = 1'b1;
    run           = 1'b0;
    tick(1);
    redirect = 1'b0;
    ir_ready = 1'b0;
    check_eq("t4c valid after", {31'h0, ir_valid}, 32'h0);
    check_eq("t4c state", {30'h0, state}, 32'h0);
    check_eq("t4c pc", {20'h0, pc}, 32'h100);
    check_eq("t4c log size", xfer_log.size(), 0);

    // PC wrap
    do_reset();
    ir_ready      = 1'b1;
    run           = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 12'hFFF;
    tick(1);
    redirect = 1'b0;
    run      = 1'b0;
    wait_state(2'b10, "t5 hold");
    check_eq("t5 ir_pc", {20'h0, ir_pc}, 32'hFFF);
    check_eq("t5 ir", {16'h0, ir}, 32'h0123);
    check_eq("t5 pc wrap", {20'h0, pc}, 32'h000);
    tick(1);
    check_eq("t5 state", {30'h0, state}, 32'h0);

    // Stop mid-REQ completes the fetch
    do_reset();
    ack_delay = 4'd3;
    ir_ready  = 1'b1;
    run       = 1'b1;
    wait_state(2'b01, "t6 req");
    stop = 1'b1;
    wait_state(2'b10, "t6 hold");
    check_eq("t6 ir", {16'h0, ir}, 32'h1234);
    tick(1);
    check_eq("t6 state", {30'h0, state}, 32'h0);
    check_eq("t6 log size", xfer_log.size(), 1);
    tick(3);
    check_eq("t6 mem_req idle", {31'h0, mem_req}, 32'h0);

    // Asynchronous reset mid-REQ
    stop = 1'b0;
    wait_state(2'b01, "t7 req");
    check_eq("t7 addr", {20'h0, mem_addr}, 32'h1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7 state", {30'h0, state}, 32'h0);
    check_eq("t7 mem_req", {31'h0, mem_req}, 32'h0);
    check_eq("t7 pc", {20'h0, pc}, 32'h0);
    check_eq("t7 ir", {16'h0, ir}, 32'h0);
    check_eq("t7 ir_pc", {20'h0, ir_pc}, 32'h0);
    check_eq("t7 ir_valid", {31'h0, ir_valid}, 32'h0);
    check_eq("t7 halted", {31'h0, halted}, 32'h0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FETCH_STEP_EN
    // Single step with run low
    do_reset();
    ir_ready = 1'b1;
    step     = 1'b1;
    tick(1);
    step = 1'b0;
    wait_state(2'b10, "t8 hold");
    tick(1);
    check_eq("t8 state", {30'h0, state}, 32'h0);
    check_eq("t8 log size", xfer_log.size(), 1);
    check_eq("t8 word0", xfer_log[0], {4'h0, 12'h000, 16'h1234});
    tick(5);
    check_eq("t8 req cycles", req_cycles, 1);
`else
    // run low never fetches
    do_reset();
    ir_ready      = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 12'h010;
    tick(1);
    redirect = 1'b0;
    tick(20);
    check_eq("t8 req cycles", req_cycles, 0);
    check_eq("t8 state", {30'h0, state}, 32'h0);
    check_eq("t8 pc", {20'h0, pc}, 32'h010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised instruction-fetch sequencer. Next generation of the single-cycle PC/IR fetch unit.
- Fetches words from an external instruction memory over a req/ack handshake, so memory latency can be variable.
- Hands each fetched instruction to decode over a valid/ready handshake.
- Supports PC redirect (jump/branch), an external stop request, and halt-word detection.

Parameters:
AW, 12, PC/memory address width
DW, 16, instruction word width
RESET_PC, 0, PC value after reset (AW bits)
HALT_WORD, {DW{1'b1}}, instruction word that halts the fetcher

Ports:
clk  in  1  clock
rst_n  in  1  reset
run  in  1  level; fetching allowed while high
stop  in  1  level; finish current fetch, then idle
redirect  in  1  one-cycle pulse; load PC from redirect_addr
redirect_addr  in  AW  new PC
mem_req  out  1  memory request, held until mem_ack
mem_addr  out  AW  fetch address, equals pc, stable while mem_req=1
mem_rdata  in  DW  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle data-valid strobe
ir_valid  out  1  ir holds an instruction for decode
ir_ready  in  1  decode accepts ir
ir  out  DW  instruction register
ir_pc  out  AW  address of the instruction in ir
pc  out  AW  next fetch address
state  out  2  IDLE=00, REQ=01, HOLD=10, HALT=11
halted  out  1  high in HALT

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk.
- Reset values: state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, mem_req=0, halted=0.
- mem_req=1 exactly when state=REQ (registered state decode).
- IDLE:
  - If run & ~stop: go to REQ next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req held high; mem_addr=pc. Zero-wait ack is legal (ack in the first REQ cycle).
  - On mem_ack with mem_rdata != HALT_WORD: ir<=mem_rdata, ir_pc<=pc, pc<=pc+1 (modulo 2^AW, so all-ones wraps to 0), ir_valid<=1, go to HOLD.
  - On mem_ack with mem_rdata == HALT_WORD: ir<=mem_rdata, ir_pc<=pc, pc unchanged, ir_valid stays 0, go to HALT.
  - stop or run falling during REQ does not abort the request; the transaction always completes.
- HOLD:
  - ir_valid=1, ir stable until ir_ready.
  - On ir_ready: ir_valid<=0; if run & ~stop go to REQ, else go to IDLE.
  - Fetch-to-decode latency is 1 cycle after mem_ack.
- HALT:
  - halted=1; all inputs ignored.
  - Exit only by reset.
- Redirect:
  - IDLE: pc<=redirect_addr; state follows the IDLE rule.
  - HOLD: ir_valid<=0 (flush, ir_ready ignored that cycle), pc<=redirect_addr, then REQ if run & ~stop, else IDLE.
  - REQ without mem_ack: latch redirect_pending=1 and the target address. mem_req stays high with the old address until ack, because the memory transaction is never abandoned. On that ack: discard data, no halt check, pc<=latched target, clear pending, stay in REQ (new request next cycle).
  - REQ with mem_ack in the same cycle: discard data, pc<=redirect_addr, stay in REQ.
  - A second redirect while pending overwrites the latched target.
  - HALT: ignored.
- redirect_pending is cleared by reset.

Optional Feature:
FETCH_STEP_EN
- Defined:
  - Adds input port step (1 bit, one-cycle pulse).
  - In IDLE, step & ~stop starts exactly one fetch (go to REQ) even when run=0.
  - After the HOLD handshake the fetcher returns to IDLE unless run=1.
  - step outside IDLE is ignored.
- Not defined: no step port; only run starts fetching.

Test Plan:
- Reset then run=1, memory at addr 0..2 = 1234,5678,9ABC, zero-wait ack, ir_ready=1 -> ir/ir_pc sequence 1234/0, 5678/1, 9ABC/2; ir_valid high 1 cycle per word; pc=3.
- Memory ack delayed 3 cycles, ir_ready held low 2 cycles -> mem_req and mem_addr stable until ack; ir stable while ir_valid=1 & ir_ready=0; no word lost or duplicated.
- Word at addr 4 = FFFF -> state=11, halted=1, ir=FFFF, ir_pc=4, ir_valid never set, pc=4; further run/redirect ignored until rst_n low.
- Redirect to 0x100 in REQ, 2 cycles before ack -> returned word discarded, next request addr=0x100; redirect coincident with ack -> same result; redirect in HOLD -> ir_valid drops next cycle.
- pc=0xFFF, fetch completes -> pc=0x000. stop asserted mid-REQ -> fetch completes, HOLD, then IDLE. rst_n low mid-REQ -> all outputs return to reset values asynchronously.
- FETCH_STEP_EN defined, run=0, step pulse -> exactly one fetch, then IDLE; not defined -> run=0 means no mem_req ever.
